ivn_lane_scheduler: RTL

IVN_LANE_SCHEDULER -- requirements
Module: ivn_lane_scheduler

---
 rtl/ivn_lane_scheduler_pkg.sv | 20 ++
 rtl/ivn_lane_scheduler_if.sv | 17 +
 rtl/ivn_lane_fifo.sv | 50 +++++
 rtl/ivn_lane_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ivn_lane_scheduler_pkg.sv
// Shared constants, FSM encoding and a width helper for the lane scheduler.
package ivn_lane_scheduler_pkg;
   localparam int NUM_LANES_DEF     = 16;
   localparam int FIFO_DEPTH_DEF    = 4;
   localparam int MAX_DWELL_DEF     = 8;
   localparam int SWITCH_CYCLES_DEF = 3;
   localparam int LANE_W            = 4;
   localparam int DROP_W            = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWITCH = 2'd1,
      RUN    = 2'd2
   } sched_state_e;

   // Bits needed to hold 0..v-1, never less than one.
   function automatic int width_of(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction
endpackage

// File: rtl/ivn_lane_scheduler_if.sv
// Scheduler bus: per-lane raw sample inputs and extractor-facing outputs.
interface ivn_lane_scheduler_if import ivn_lane_scheduler_pkg::*; #(
   parameter int NUM_LANES = NUM_LANES_DEF
);
   logic [NUM_LANES-1:0] raw_bit;
   logic [NUM_LANES-1:0] raw_valid;
   logic [NUM_LANES-1:0] raw_ready;
   logic [LANE_W-1:0]    lane;
   logic                 s;
   logic                 s_valid;
   logic [DROP_W-1:0]    drop_cnt;

   modport master (output raw_bit, raw_valid,
                   input  raw_ready, lane, s, s_valid, drop_cnt);
   modport slave  (input  raw_bit, raw_valid,
                   output raw_ready, lane, s, s_valid, drop_cnt);
endinterface

// File: rtl/ivn_lane_fifo.sv
// Single-bit per-lane sample FIFO; pushes to a full FIFO are discarded.
module ivn_lane_fifo import ivn_lane_scheduler_pkg::*; #(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty,
   output logic last
);
   localparam int PW = width_of(DEPTH);
   localparam int CW = width_of(DEPTH + 1);

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok, pop_ok;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // full comes from registered count, so a same-cycle pop never frees room
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign last    = (count == CW'(1));
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= nxt(wr_ptr);
         if (pop_ok)  rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end
endmodule

// File: rtl/ivn_lane_scheduler.sv
// Round-robin entropy lane scheduler with dwell limit and switch gap.
// IVN_SCHED_DROP_CNT_EN enables the saturating dropped-sample counter.
module ivn_lane_scheduler import ivn_lane_scheduler_pkg::*; #(
   parameter int NUM_LANES     = NUM_LANES_DEF,
   parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
   parameter int MAX_DWELL     = MAX_DWELL_DEF,
   parameter int SWITCH_CYCLES = SWITCH_CYCLES_DEF
) (
   input logic                 clk,
   input logic                 reset,
   ivn_lane_scheduler_if.slave bus
);
   localparam int DW = width_of(MAX_DWELL + 1);
   localparam int SW = width_of(SWITCH_CYCLES);

   sched_state_e         state, state_n;
   logic [LANE_W-1:0]    lane, lane_n, oth_win;
   logic [DW-1:0]        dwell, dwell_n;
   logic [SW-1:0]        sw_cnt, sw_cnt_n;
   logic [NUM_LANES-1:0] full, empty, last, head, pop_vec;
   logic                 oth_found, s_valid, last_bit, drain;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      ivn_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (bus.raw_valid[i]),
         .din   (bus.raw_bit[i]),
         .pop   (pop_vec[i]),
         .dout  (head[i]),
         .full  (full[i]),
         .empty (empty[i]),
         .last  (last[i])
      );
   end

   assign s_valid = (state == RUN) & ~empty[lane];
   // lane drains this cycle unless a fresh sample lands behind the last bit
   assign last_bit = s_valid & last[lane] & ~(bus.raw_valid[lane] & ~full[lane]);
   assign drain    = ~s_valid | last_bit;

   always_comb begin
      pop_vec       = '0;
      pop_vec[lane] = s_valid;
   end

   // Nearest non-empty lane after the current one, wrapping, excluding itself
   always_comb begin
      int                t;
      logic [LANE_W-1:0] idx;
      oth_found = 1'b0;
      oth_win   = lane;
      for (int k = NUM_LANES - 1; k >= 1; k--) begin
         t = int'(lane) + k;
         if (t >= NUM_LANES) t = t - NUM_LANES;
         idx = LANE_W'(t);
         if (!empty[idx]) begin
            oth_found = 1'b1;
            oth_win   = idx;
         end
      end
   end

   always_comb begin
      state_n  = state;
      lane_n   = lane;
      dwell_n  = dwell;
      sw_cnt_n = sw_cnt;
      case (state)
         IDLE: begin
            dwell_n = '0;
            if (oth_found) begin
               state_n  = SWITCH;
               lane_n   = oth_win;
               sw_cnt_n = '0;
            end else if (!empty[lane]) begin
               state_n = RUN;
            end
         end
         SWITCH: begin
            if (sw_cnt == SW'(SWITCH_CYCLES - 1)) begin
               state_n  = RUN;
               sw_cnt_n = '0;
               dwell_n  = '0;
            end else begin
               sw_cnt_n = sw_cnt + 1'b1;
            end
         end
         RUN: begin
            dwell_n = dwell + DW'(s_valid);
            if (drain || dwell_n == DW'(MAX_DWELL)) begin
               dwell_n = '0;
               if (oth_found) begin
                  state_n  = SWITCH;
                  lane_n   = oth_win;
                  sw_cnt_n = '0;
               end else if (drain) begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         lane   <= '0;
         dwell  <= '0;
         sw_cnt <= '0;
      end else begin
         state  <= state_n;
         lane   <= lane_n;
         dwell  <= dwell_n;
         sw_cnt <= sw_cnt_n;
      end
   end

   assign bus.raw_ready = ~full;
   assign bus.lane      = lane;
   assign bus.s_valid   = s_valid;
   assign bus.s         = s_valid & head[lane];

`ifdef IVN_SCHED_DROP_CNT_EN
   localparam int PCW  = width_of(NUM_LANES + 1);
   localparam int SUMW = DROP_W + 1;

   logic [PCW-1:0]    n_drop;
   logic [SUMW-1:0]   drop_sum;
   logic [DROP_W-1:0] drop_cnt;

   always_comb begin
      n_drop = '0;
      for (int i = 0; i < NUM_LANES; i++) n_drop = n_drop + PCW'(bus.raw_valid[i] & full[i]);
   end

   assign drop_sum = {1'b0, drop_cnt} + SUMW'(n_drop);

   always_ff @(posedge clk) begin
      if (reset) drop_cnt <= '0;
      else       drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
   end

   assign bus.drop_cnt = drop_cnt;
`else
   assign bus.drop_cnt = '0;
`endif
endmodule
